// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder slice.
//   state_t     : responder FSM state encodings (IDLE / WAIT / RESP)
//   WORD_BYTES  : bytes per memory word
//   idx_width() : width of the word index for a given array depth
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   localparam int WORD_BYTES = 4;

   // DEPTH_WORDS is a power of two >= 2, so this is an exact log2.
   function automatic int idx_width(input int depth_words);
      return $clog2(depth_words);
   endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Word array behind the responder.
//   clk   : write clock (rising edge)
//   we    : write strobe, commits enabled bytes of wdata at addr
//   addr  : word index, shared by the read and write ports
//   wdata : write data
//   be    : byte enables, bit i covers wdata[8i+7:8i]
//   rdata : combinational read of the word at addr
// Contents are not reset.
module dmem_array
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int IW          = idx_width(DEPTH_WORDS)
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [IW-1:0]           addr,
   input  logic [31:0]             wdata,
   input  logic [WORD_BYTES-1:0]   be,
   output logic [31:0]             rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (be[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder. Accepts one word request at a time,
// completes it LATENCY edges later and stalls the pipeline meanwhile.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   req_*       : request from the pipeline (valid, write, byte address,
//                 store data, store byte enables)
//   req_ready   : high while idle, i.e. a request can be accepted
//   resp_valid  : one-cycle completion pulse
//   resp_rdata  : load data (0 for stores and faulting requests)
//   resp_err    : misaligned or out-of-range address
//   mem_stall   : pipeline must hold its stage registers this cycle
//
// Handshake: a request is accepted on a rising edge where the FSM is idle
// and req_valid is high; req_ready only reports idleness, it is not
// required by the requester. Exactly one resp_valid pulse follows each
// accepted request unless reset intervenes.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_stall
);

   localparam int IW = idx_width(DEPTH_WORDS);
   localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

   state_t        state, state_nx;
   logic [CW-1:0] cnt;

   logic          cap_write;
   logic [31:0]   cap_addr;
   logic [31:0]   cap_wdata;
   logic [3:0]    cap_be;

   logic          accept;
   logic          enter_resp;
   logic          eff_write;
   logic [31:0]   eff_addr;
   logic [31:0]   eff_wdata;
   logic [3:0]    eff_be;
   logic          misaligned;
   logic          out_of_range;
   logic          err;
   logic [IW-1:0] index;
   logic          arr_we;
   logic [31:0]   arr_rdata;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (req_valid) state_nx = (LATENCY > 1) ? ST_WAIT : ST_RESP;
         ST_WAIT: if (cnt == CW'(1)) state_nx = ST_RESP;
         ST_RESP: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   assign accept     = (state == ST_IDLE) && req_valid;
   // RESP always exits after one cycle, so heading to RESP means entering it.
   assign enter_resp = (state_nx == ST_RESP);

   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign mem_stall  = accept || (state == ST_WAIT);

   // ---------------- capture and latency counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_be    <= '0;
      end else if (accept) begin
         cnt       <= CW'(LATENCY - 1);
         cap_write <= req_write;
         cap_addr  <= req_addr;
         cap_wdata <= req_wdata;
         cap_be    <= req_be;
      end else if (state == ST_WAIT) begin
         cnt <= cnt - CW'(1);
      end
   end

   // With LATENCY=1 the accepting edge is also the edge entering RESP, so
   // the request is decoded straight from the inputs while idle.
   assign eff_write = (state == ST_IDLE) ? req_write : cap_write;
   assign eff_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
   assign eff_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;
   assign eff_be    = (state == ST_IDLE) ? req_be    : cap_be;

   // ---------------- address decode ----------------
   assign misaligned   = |eff_addr[1:0];
   assign out_of_range = |eff_addr[31:IW+2];
   assign err          = misaligned || out_of_range;
   assign index        = eff_addr[IW+1:2];

   assign arr_we = enter_resp && eff_write && !err;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .addr  (index),
      .wdata (eff_wdata),
      .be    (eff_be),
      .rdata (arr_rdata)
   );

   // ---------------- response registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else if (enter_resp) begin
         resp_err   <= err;
         resp_rdata <= (eff_write || err) ? 32'h0 : arr_rdata;
      end else begin
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 uses LATENCY=2, instance 1 uses
// LATENCY=1, both with DEPTH_WORDS=256. A transaction-level model (reference
// memory plus "response due at cycle N" bookkeeping) is checked on every
// falling edge; directed sequences add hand-computed literal checks.
module tb_data_mem_responder;

   localparam int DEPTH = 256;

   logic        clk;
   logic        rst_n;
   logic        req_valid [2];
   logic        req_write [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_be    [2];
   logic        rdy       [2];
   logic        vld       [2];
   logic [31:0] rdata     [2];
   logic        err       [2];
   logic        stall     [2];

   int n_vec  = 0;
   int n_fail = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .req_ready(rdy[0]), .resp_valid(vld[0]), .resp_rdata(rdata[0]),
      .resp_err(err[0]), .mem_stall(stall[0])
   );

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .req_ready(rdy[1]), .resp_valid(vld[1]), .resp_rdata(rdata[1]),
      .resp_err(err[1]), .mem_stall(stall[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- model / scoreboard ----------------
   logic [31:0] ref_mem [longint];
   bit          busy     [2];
   int          due      [2];
   logic        pend_w   [2];
   logic [31:0] pend_a   [2];
   logic [31:0] pend_d   [2];
   logic [3:0]  pend_be  [2];
   int          ncyc = 0;
   int          pulses [2];

   always @(negedge clk) begin
      int          lat;
      logic        e_ready, e_valid, e_stall, e_err;
      longint      key;
      logic [31:0] word;
      ncyc++;
      for (int k = 0; k < 2; k++) begin
         lat = (k == 0) ? 2 : 1;
         e_ready = 1'b1; e_valid = 1'b0; e_stall = 1'b0;
         if (vld[k] === 1'b1) pulses[k]++;
         if (rst_n !== 1'b1) begin
            busy[k] = 0;
         end else if (!busy[k]) begin
            e_stall = req_valid[k];
            if (req_valid[k]) begin
               busy[k]    = 1;
               due[k]     = ncyc + lat;
               pend_w[k]  = req_write[k];
               pend_a[k]  = req_addr[k];
               pend_d[k]  = req_wdata[k];
               pend_be[k] = req_be[k];
            end
         end else if (ncyc < due[k]) begin
            e_ready = 1'b0;
            e_stall = 1'b1;
         end else begin
            e_ready = 1'b0;
            e_valid = 1'b1;
            busy[k] = 0;
            e_err = (pend_a[k] % 4 != 0) || (pend_a[k] >= DEPTH * 4);
            key = (longint'(k) << 32) | longint'(pend_a[k]);
            check("m_err", 32'(err[k]), 32'(e_err));
            if (!pend_w[k]) begin
               if (e_err) check("m_rdata", rdata[k], 32'h0);
               else       check("m_rdata", rdata[k], ref_mem[key]);
            end else if (!e_err) begin
               word = ref_mem.exists(key) ? ref_mem[key] : 32'hx;
               for (int b = 0; b < 4; b++)
                  if (pend_be[k][b]) word[8*b +: 8] = pend_d[k][8*b +: 8];
               ref_mem[key] = word;
            end
         end
         check("m_ready", 32'(rdy[k]), 32'(e_ready));
         check("m_valid", 32'(vld[k]), 32'(e_valid));
         check("m_stall", 32'(stall[k]), 32'(e_stall));
         if (!e_valid) begin
            check("m_idle_rdata", rdata[k], 32'h0);
            check("m_idle_err", 32'(err[k]), 32'h0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic [31:0] last_rdata;
   logic        last_err;
   int          stall_cnt;

   task automatic drive_idle(input int k);
      req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0;
   endtask

   // One request; the address/data inputs are scrambled after acceptance.
   task automatic do_req(input int k, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
      bit got = 0;
      @(posedge clk); #1;
      req_valid[k] = 1'b1; req_write[k] = w; req_addr[k] = a;
      req_wdata[k] = d; req_be[k] = be;
      stall_cnt = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (stall[k]) stall_cnt++;
         if (vld[k]) begin
            got = 1; last_rdata = rdata[k]; last_err = err[k];
         end else begin
            @(posedge clk); #1;
            req_addr[k] = $urandom; req_wdata[k] = $urandom;
         end
      end
      if (!got) begin
         n_vec++; n_fail++;
         $display("FAIL timeout: no resp_valid on inst %0d addr %h", k, a);
      end
      @(posedge clk); #1;
      drive_idle(k);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int t0, t1, np, p0;
      rst_n = 1'b0;
      drive_idle(0); drive_idle(1);
      repeat (3) @(posedge clk);
      check("rst_ready", 32'(rdy[0]), 32'h1);
      check("rst_valid", 32'(vld[0]), 32'h0);
      check("rst_stall", 32'(stall[0]), 32'h0);
      #1 rst_n = 1'b1;

      // store then load, LATENCY=2
      do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111);
      check("st_stall_cycles", 32'(stall_cnt), 32'd2);
      check("st_err", 32'(last_err), 32'h0);
      do_req(0, 0, 32'h10, 32'h0, 4'b0000);
      check("ld_10", last_rdata, 32'hDEADBEEF);

      // partial store
      do_req(0, 1, 32'h10, 32'h11223344, 4'b1111);
      do_req(0, 1, 32'h10, 32'hAABBCCDD, 4'b0101);
      do_req(0, 0, 32'h10, 32'h0, 4'b0000);
      check("ld_partial", last_rdata, 32'h11BB33DD);

      // misaligned load
      do_req(0, 0, 32'h12, 32'h0, 4'b0000);
      check("mis_err", 32'(last_err), 32'h1);
      check("mis_rdata", last_rdata, 32'h0);

      // out-of-range stores leave word 0 alone
      do_req(0, 1, 32'h0, 32'h55AA55AA, 4'b1111);
      do_req(0, 1, 32'h400, 32'hFFFFFFFF, 4'b1111);
      check("oor_err", 32'(last_err), 32'h1);
      do_req(0, 1, 32'h8000_0000, 32'hFFFFFFFF, 4'b1111);
      check("oor_hi_err", 32'(last_err), 32'h1);
      do_req(0, 0, 32'h0, 32'h0, 4'b0000);
      check("ld_0_after_oor", last_rdata, 32'h55AA55AA);

      // empty byte mask: completes, no write, no error
      do_req(0, 1, 32'h0, 32'h0, 4'b0000);
      check("be0_err", 32'(last_err), 32'h0);
      do_req(0, 0, 32'h0, 32'h0, 4'b0000);
      check("ld_0_after_be0", last_rdata, 32'h55AA55AA);

      // reset while in WAIT discards the store
      do_req(0, 1, 32'h20, 32'hCAFEF00D, 4'b1111);
      p0 = pulses[0];
      @(posedge clk); #1;
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
      req_wdata[0] = 32'h12345678; req_be[0] = 4'b1111;
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive_idle(0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      check("rst_no_pulse", 32'(pulses[0] - p0), 32'h0);
      do_req(0, 0, 32'h20, 32'h0, 4'b0000);
      check("ld_20_after_rst", last_rdata, 32'hCAFEF00D);

      // LATENCY=1: stores, then back-to-back loads with req_valid held high
      do_req(1, 1, 32'h8, 32'h0BADF00D, 4'b1111);
      check("l1_stall_cycles", 32'(stall_cnt), 32'd1);
      do_req(1, 1, 32'hC, 32'h600DCAFE, 4'b1111);
      @(posedge clk); #1;
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h8;
      @(posedge clk); #1;
      req_addr[1] = 32'hC;
      np = 0; t0 = 0; t1 = 0;
      for (int c = 0; c < 8 && np < 2; c++) begin
         @(negedge clk);
         if (vld[1]) begin
            if (np == 0) begin
               t0 = c; check("b2b_rdata0", rdata[1], 32'h0BADF00D);
            end else begin
               t1 = c; check("b2b_rdata1", rdata[1], 32'h600DCAFE);
            end
            check("b2b_ready_in_resp", 32'(rdy[1]), 32'h0);
            np++;
         end
         if (np < 2) begin
            @(posedge clk); #1;
         end
      end
      check("b2b_pulses", 32'(np), 32'd2);
      check("b2b_gap", 32'(t1 - t0), 32'd2);
      @(posedge clk); #1;
      drive_idle(1);
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
